riscv_mmio_uart_tx: RTL and testbench



---
 rtl/riscv_mmio_uart_tx_if.sv | 21 ++
 rtl/riscv_mmio_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_riscv_mmio_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mmio_uart_tx_if.sv
// rtl/riscv_mmio_uart_tx_if.sv - CPU data-side load/store port seen by the UART transmitter
interface riscv_mmio_uart_tx_if;
  logic        cache_d_write_en;
  logic [31:0] addr;
  logic [31:0] data_to_cache;
  logic [31:0] data_out;

  modport master (
    output cache_d_write_en,
    output addr,
    output data_to_cache,
    input  data_out
  );

  modport slave (
    input  cache_d_write_en,
    input  addr,
    input  data_to_cache,
    output data_out
  );
endinterface

// File: rtl/riscv_mmio_uart_tx.sv
// rtl/riscv_mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter (TXDATA/STATUS/DIV window)
// Define UART_TX_FIFO_EN for a 4-entry transmit FIFO; otherwise a single holding register.
module riscv_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FC80,
  parameter logic [15:0] DEFAULT_DIV = 16'd200
) (
  input  logic                clk,
  input  logic                rst,
  riscv_mmio_uart_tx_if.slave bus,
  output logic                uart_tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state, state_n;
  logic [31:0] off;
  logic        hit;
  logic [1:0]  reg_sel;
  logic        wr_txdata, wr_status, wr_div;
  logic        push, pop, q_accept;
  logic        q_empty, q_full;
  logic [7:0]  q_head;
  logic        ovf;
  logic [15:0] div, div_lat, baud_cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        period_end;
  logic        busy;
  logic        unused_bits;

  assign off       = bus.addr - BASE_ADDR;
  assign hit       = (off[31:4] == 28'd0);
  assign reg_sel   = off[3:2];
  assign wr_txdata = bus.cache_d_write_en && hit && (reg_sel == 2'd0);
  assign wr_status = bus.cache_d_write_en && hit && (reg_sel == 2'd1);
  assign wr_div    = bus.cache_d_write_en && hit && (reg_sel == 2'd2);
  assign push      = wr_txdata;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign q_accept  = push && (!q_full || pop);
  assign unused_bits = ^{off[1:0], bus.data_to_cache[31:16]};

`ifdef UART_TX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;

  assign q_empty = (count == 3'd0);
  assign q_full  = (count == 3'd4);
  assign q_head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (q_accept) begin
        mem[wr_ptr] <= bus.data_to_cache[7:0];
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, q_accept} - {2'b00, pop};
    end
  end
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign q_empty = !hold_valid;
  assign q_full  = hold_valid;
  assign q_head  = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (q_accept) begin
      hold       <= bus.data_to_cache[7:0];
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      if (push && q_full && !pop) ovf <= 1'b1;
      else if (wr_status && bus.data_to_cache[3]) ovf <= 1'b0;
      if (wr_div) div <= bus.data_to_cache[15:0];
    end
  end

  assign busy       = (state != S_IDLE);
  assign period_end = (baud_cnt == div_lat - 16'd1);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: if (period_end) state_n = S_DATA;
      S_DATA:  if (period_end && bit_cnt == 3'd7) state_n = S_STOP;
      S_STOP: begin
        if (period_end) begin
          if (!q_empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // div_lat is captured only at pop so DIV writes never stretch a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      div_lat  <= 16'd2;
      shift    <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      state <= state_n;
      if (pop) begin
        shift    <= q_head;
        div_lat  <= (div < 16'd2) ? 16'd2 : div;
        bit_cnt  <= 3'd0;
        baud_cnt <= 16'd0;
      end else if (state != S_IDLE) begin
        baud_cnt <= period_end ? 16'd0 : baud_cnt + 16'd1;
        if (state == S_DATA && period_end) begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      case (state)
        S_START: uart_tx <= 1'b0;
        S_DATA:  uart_tx <= shift[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  always_comb begin
    bus.data_out = 32'd0;
    if (hit) begin
      case (reg_sel)
        2'd1:    bus.data_out = {28'd0, ovf, q_empty, q_full, busy};
        2'd2:    bus.data_out = {16'd0, div};
        default: bus.data_out = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// tb/tb_riscv_mmio_uart_tx.sv - scoreboard bench: stores queue expected frames, a line monitor decodes uart_tx
module tb_riscv_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_FC80;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'h4;
  localparam logic [31:0] DIVR = BASE + 32'h8;

  typedef struct {
    logic [7:0] b;
    int         per;
    bit         b2b;
  } exp_t;

  logic clk;
  logic rst;
  logic uart_tx;
  int   checks;
  int   passes;
  int   idle_cnt;
  int   frame_no;
  exp_t exp_q[$];

  riscv_mmio_uart_tx_if bus ();

  riscv_mmio_uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.cache_d_write_en = we;
    bus.addr             = a;
    bus.data_to_cache    = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, a, d);
    @(negedge clk);
    drive(1'b0, STA, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0);
    #1;
    chk(name, bus.data_out, exp);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int per, input bit b2b);
    exp_t e;
    e.b = b; e.per = per; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    drive(1'b0, STA, 32'd0);
    @(negedge clk);
    while (bus.data_out !== 32'h4 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("status_idle", bus.data_out, 32'h4);
    repeat (3) @(negedge clk);
    chk("frames_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: every sample of every bit period must hold the expected level.
  task automatic check_frame();
    exp_t       e;
    logic [7:0] got;
    logic       exp_bit;
    bit         bad;
    bit         aborted;
    int         n;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_frame: start bit seen with no byte queued, required idle line");
      n = 0;
      while (uart_tx === 1'b0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      return;
    end
    e = exp_q.pop_front();
    got = 8'd0;
    bad = (e.b2b && idle_cnt != 0);
    aborted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : e.b[i-1];
      for (int c = 0; c < e.per; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (uart_tx !== exp_bit) bad = 1'b1;
        if (c == e.per / 2 && i >= 1 && i <= 8) got[i-1] = uart_tx;
      end
      if (aborted) break;
    end
    idle_cnt = 0;
    if (!aborted) begin
      checks++;
      frame_no++;
      if (!bad && got === e.b) passes++;
      else $display("FAIL frame%0d: got byte 0x%02h levels_ok=%0d gap=%0d, required byte 0x%02h at %0d clk/bit",
                    frame_no, got, !bad, idle_cnt, e.b, e.per);
    end
  endtask

  initial begin
    idle_cnt = 0;
    frame_no = 0;
    forever begin
      @(negedge clk);
      if (rst) idle_cnt = 0;
      else if (uart_tx === 1'b0) check_frame();
      else idle_cnt++;
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, uart_tx}, 32'd1);
    rst = 1'b0;

    rd_chk("reset_status", STA, 32'h4);
    rd_chk("reset_div", DIVR, 32'd200);
    rd_chk("txdata_reads_0", TXD, 32'd0);
    rd_chk("off_c_reads_0", BASE + 32'hC, 32'd0);
    rd_chk("outside_reads_0", 32'h0000_1008, 32'd0);
    wr(BASE + 32'hC, 32'h0000_1234);
    rd_chk("off_c_write_ignored", DIVR, 32'd200);

    // 0x55 at 4 clocks/bit, plus store-to-start-bit latency
    wr(DIVR, 32'h0001_0004);
    rd_chk("div_write", DIVR, 32'd4);
    expect_frame(8'h55, 4, 1'b0);
    @(negedge clk);
    drive(1'b1, TXD, 32'h0000_0055);
    @(negedge clk);
    drive(1'b0, STA, 32'd0);
    @(posedge clk); #1;
    chk("tx_high_after_pop", {31'd0, uart_tx}, 32'd1);
    @(posedge clk); #1;
    chk("tx_start_at_n2", {31'd0, uart_tx}, 32'd0);
    wait_idle(1000);

`ifdef UART_TX_FIFO_EN
    wr(DIVR, 32'd2);
    for (int k = 1; k <= 5; k++) expect_frame(8'(k), 2, k > 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(1'b1, TXD, 32'(k));
    end
    @(negedge clk);
    rd_chk("fifo_full", STA, 32'h3);
    drive(1'b1, TXD, 32'h6);
    @(negedge clk);
    rd_chk("fifo_ovf", STA, 32'hB);
    wr(STA, 32'h8);
    rd_chk("fifo_ovf_clear", STA, 32'h3);
    wait_idle(1000);
`else
    wr(DIVR, 32'd4);
    expect_frame(8'h3C, 4, 1'b0);
    expect_frame(8'hA5, 4, 1'b1);
    expect_frame(8'hC3, 4, 1'b1);
    @(negedge clk);
    drive(1'b1, TXD, 32'h3C);
    @(negedge clk);
    drive(1'b1, TXD, 32'hA5);
    @(negedge clk);
    drive(1'b0, STA, 32'd0);
    repeat (39) @(negedge clk);
    rd_chk("hold_full_before_pop", STA, 32'h3);
    drive(1'b1, TXD, 32'hC3);
    @(negedge clk);
    rd_chk("push_on_pop_accepted", STA, 32'h3);
    drive(1'b1, TXD, 32'h99);
    @(negedge clk);
    rd_chk("hold_ovf", STA, 32'hB);
    wr(STA, 32'h8);
    rd_chk("hold_ovf_clear", STA, 32'h3);
    wait_idle(1000);
`endif

    // DIV below 2 is clamped to 2 clocks/bit
    wr(DIVR, 32'd1);
    rd_chk("div_one_readback", DIVR, 32'h1);
    expect_frame(8'hFF, 2, 1'b0);
    wr(TXD, 32'hFF);
    wait_idle(1000);

    // DIV change mid-frame takes effect on the next frame only
    wr(DIVR, 32'd4);
    expect_frame(8'h81, 4, 1'b0);
    expect_frame(8'h7E, 8, 1'b1);
    wr(TXD, 32'h81);
    wr(TXD, 32'h7E);
    repeat (10) @(negedge clk);
    wr(DIVR, 32'd8);
    rd_chk("div_mid_frame", DIVR, 32'd8);
    wait_idle(1000);

    // Reset during DATA bit 3 of 0x07 (bit 3 is a 0)
    wr(DIVR, 32'd4);
    expect_frame(8'h07, 4, 1'b0);
    wr(TXD, 32'h07);
    repeat (18) @(negedge clk);
    chk("tx_in_bit3", {31'd0, uart_tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("tx_high_after_reset", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("status_after_reset", STA, 32'h4);
    rd_chk("div_after_reset", DIVR, 32'd200);
    rd_chk("beyond_window_0", BASE + 32'h10, 32'd0);
    repeat (50) @(negedge clk);
    chk("tx_idle_after_reset", {31'd0, uart_tx}, 32'd1);
    chk("aborted_frame_popped", 32'(exp_q.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
